mapper_konami_gen: RTL and testbench
====================================

Name: mapper_konami_gen

Overview:
Parametrised Konami MegaROM mapper for the MSX cartridge slot path. It supports Konami4 (no SCC) and Konami5 (SCC) bank-switching modes, with configurable bank-register width and a ROM base offset. It sits between the CPU bus decode and the SDRAM address mux. It replaces the fixed all-inactive mapper output with a live 4-page 8 KB banking scheme and an SCC window select.

Parameters:
MODE, 0, 0 = Konami4 (no SCC), 1 = Konami5/SCC
BANK_BITS, 8, width of each bank register (1..8); number of addressable 8 KB banks is 2^BANK_BITS
ADDR_W, 27, width of the physical memory address output

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cs  in  1  slot/subslot select for this cartridge
addr  in  16  CPU address
data  in  8  CPU write data
wr  in  1  CPU write strobe, one clk wide per access
rd  in  1  CPU read strobe
rom_base  in  ADDR_W  physical start of the ROM image
rom_mask  in  BANK_BITS  bank mask = (ROM size in 8 KB pages) - 1
out_addr  out  ADDR_W  physical address; all ones when idle
out_ram_cs  out  1  ROM fetch select
out_sram_cs  out  1  always 0 (no SRAM on Konami carts)
out_rnw  out  1  always 1 (ROM is read-only)
scc_cs  out  1  SCC register window select (MODE=1 only)
scc_en  out  1  SCC window currently enabled

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high (port reset). Reset has priority over a same-cycle write.
- State: four bank registers bank0..bank3, each BANK_BITS wide. Reset values are 0, 1, 2 and 3, truncated to BANK_BITS.
- Page decode uses addr[15:13]:
  - 010 → page0 (4000-5FFF)
  - 011 → page1 (6000-7FFF)
  - 100 → page2 (8000-9FFF)
  - 101 → page3 (A000-BFFF)
  - any other value is outside the window.
- Bank writes are sampled on the rising clk edge where cs & wr are both 1. The new value is visible from the next cycle. Writes without cs are ignored.
- MODE 0 bank writes:
  - 6000-7FFF → bank1
  - 8000-9FFF → bank2
  - A000-BFFF → bank3
  - writes to 4000-5FFF are ignored; bank0 stays 0 permanently.
- MODE 1 bank writes:
  - 5000-57FF → bank0
  - 7000-77FF → bank1
  - 9000-97FF → bank2
  - B000-B7FF → bank3
  - all other write addresses do not touch the bank registers.
- Bank capture: register = data[BANK_BITS-1:0], stored unmasked. Masking is applied only at address generation.
- Address generation is combinational from addr and the current registers, with zero latency:
  - out_addr = rom_base + ({bankN & rom_mask, addr[12:0]}), zero-extended to ADDR_W.
  - The sum wraps modulo 2^ADDR_W.
- out_ram_cs = cs & rd & in-window & ~scc_cs.
  - When out_ram_cs=0: out_addr = all ones.
  - Writes never assert out_ram_cs.
- SCC (MODE 1 only):
  - scc_en = (bank2[5:0] == 6'h3F). If BANK_BITS < 6, compare the available bits against all ones.
  - scc_cs = cs & (rd|wr) & scc_en & addr in 9800-9FFF.
  - A write to 9000-97FF that clears scc_en takes effect the next cycle.
  - In MODE 0, scc_cs = scc_en = 0 always.
- Constant outputs: out_sram_cs=0 and out_rnw=1 in all states.
- Reset mid-access: outputs reflect the reset bank values from the cycle after reset is sampled.

Test Plan:
- Reset, MODE 0, rom_base=0, rom_mask=8'h0F; read 0x4000/0x6000/0x8000/0xA000 → out_addr 0x00000, 0x02000, 0x04000, 0x06000; out_ram_cs=1.
- MODE 0: write 0x05 to 0x6000, then read 0x6123 → out_addr 0x0A123. Write 0x07 to 0x4000, then read 0x4000 → out_addr 0x00000 (bank0 unchanged).
- MODE 1, rom_mask=8'h07, rom_base=0x100000: write 0x1B to 0xB000, then read 0xA010 → out_addr 0x100000+0x06010 (0x1B&7=3) = 0x106010. Write to 0xB800 → bank3 unchanged.
- MODE 1: write 0x3F to 0x9000 → scc_en=1 next cycle. Read 0x9800 → scc_cs=1, out_ram_cs=0, out_addr all ones. Read 0x8000 → ROM bank 0x3F&mask.
- Write to 0x6000 with cs=0 → no change; read 0xC000 with cs=1 → out_ram_cs=0, out_addr=27'h7FFFFFF. Reset asserted in the same cycle as a write to 0x6000 → bank1=1.
- Constant checks in every scenario: out_sram_cs=0 and out_rnw=1. MODE 0 with a 0x3F write to 0x9000 → scc_en stays 0.

Source files
------------

// File: rtl/mapper_konami_gen.sv
// ---------------------------------------------------------------------------
// mapper_konami_gen
// Konami MegaROM mapper for the MSX cartridge slot path. Banks the
// 4000-BFFF CPU window as four 8 KB pages onto a ROM image in physical
// memory. MODE 0 is Konami4 (no SCC). MODE 1 is Konami5, which adds the
// SCC register window at 9800-9FFF.
//
// Parameters:
//   MODE      : 0 = Konami4, 1 = Konami5/SCC
//   BANK_BITS : width of each bank register (1..8)
//   ADDR_W    : width of the physical address output
//
// Ports:
//   clk, reset   : clock and synchronous active-high reset
//   cs           : cartridge slot select
//   addr, data   : CPU address and write data
//   wr, rd       : CPU write and read strobes
//   rom_base     : physical start of the ROM image
//   rom_mask     : bank mask, equal to the ROM page count minus one
//   out_addr     : physical fetch address; all ones when not fetching
//   out_ram_cs   : ROM fetch select
//   out_sram_cs  : tied low, because Konami carts have no SRAM
//   out_rnw      : tied high, because the ROM is read-only
//   scc_cs       : SCC register window select
//   scc_en       : SCC window currently enabled
// ---------------------------------------------------------------------------
module mapper_konami_gen #(
    parameter int MODE      = 0,
    parameter int BANK_BITS = 8,
    parameter int ADDR_W    = 27
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic [15:0]          addr,
    input  logic [7:0]           data,
    input  logic                 wr,
    input  logic                 rd,
    input  logic [ADDR_W-1:0]    rom_base,
    input  logic [BANK_BITS-1:0] rom_mask,
    output logic [ADDR_W-1:0]    out_addr,
    output logic                 out_ram_cs,
    output logic                 out_sram_cs,
    output logic                 out_rnw,
    output logic                 scc_cs,
    output logic                 scc_en
);

    // The SCC enable compares bank2[5:0]; narrower banks compare the bits they have.
    localparam int SCC_BITS = (BANK_BITS < 6) ? BANK_BITS : 6;

    logic [BANK_BITS-1:0] bank_q [4];
    logic [BANK_BITS-1:0] bank_d [4];
    logic                 wr_hit_s;
    logic [1:0]           wr_idx_s;
    logic                 win_s;
    logic [BANK_BITS-1:0] sel_bank_s;
    logic                 scc_en_s;
    logic                 scc_cs_s;
    logic                 scc_win_s;
    logic                 ram_cs_s;
    logic [ADDR_W-1:0]    offset_s;
    logic [ADDR_W-1:0]    sum_s;

    // Bank-register write decode. Konami5 uses 2 KB write windows, and
    // Konami4 uses whole pages with page0 locked to bank 0.
    always_comb begin
        wr_hit_s = 1'b0;
        wr_idx_s = 2'd0;
        if (cs && wr) begin
            if (MODE == 1) begin
                case (addr[15:11])
                    5'b01010: begin wr_hit_s = 1'b1; wr_idx_s = 2'd0; end
                    5'b01110: begin wr_hit_s = 1'b1; wr_idx_s = 2'd1; end
                    5'b10010: begin wr_hit_s = 1'b1; wr_idx_s = 2'd2; end
                    5'b10110: begin wr_hit_s = 1'b1; wr_idx_s = 2'd3; end
                    default:  begin wr_hit_s = 1'b0; wr_idx_s = 2'd0; end
                endcase
            end else begin
                case (addr[15:13])
                    3'b011:  begin wr_hit_s = 1'b1; wr_idx_s = 2'd1; end
                    3'b100:  begin wr_hit_s = 1'b1; wr_idx_s = 2'd2; end
                    3'b101:  begin wr_hit_s = 1'b1; wr_idx_s = 2'd3; end
                    default: begin wr_hit_s = 1'b0; wr_idx_s = 2'd0; end
                endcase
            end
        end else begin
            wr_hit_s = 1'b0;
            wr_idx_s = 2'd0;
        end
    end

    // Next bank values. The register is stored unmasked, and the mask is
    // applied only when the address is formed.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (wr_hit_s && (wr_idx_s == 2'(i))) begin
                bank_d[i] = data[BANK_BITS-1:0];
            end else begin
                bank_d[i] = bank_q[i];
            end
        end
    end

    // Bank registers. Reset takes priority over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= BANK_BITS'(i);
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= bank_d[i];
            end
        end
    end

    // Page decode for reads: select the bank that backs the addressed page.
    always_comb begin
        win_s      = 1'b1;
        sel_bank_s = {BANK_BITS{1'b0}};
        case (addr[15:13])
            3'b010:  sel_bank_s = bank_q[0];
            3'b011:  sel_bank_s = bank_q[1];
            3'b100:  sel_bank_s = bank_q[2];
            3'b101:  sel_bank_s = bank_q[3];
            default: win_s      = 1'b0;
        endcase
    end

    // SCC window. It is enabled while bank2 selects page 3F, and it shadows
    // ROM at 9800-9FFF.
    always_comb begin
        scc_win_s = (addr[15:11] == 5'b10011);
        if (MODE == 1) begin
            scc_en_s = &bank_q[2][SCC_BITS-1:0];
        end else begin
            scc_en_s = 1'b0;
        end
        scc_cs_s = cs & (rd | wr) & scc_en_s & scc_win_s;
    end

    // Physical address. The sum wraps at ADDR_W, and the address is forced
    // to all ones when no ROM fetch is taking place.
    always_comb begin
        ram_cs_s = cs & rd & win_s & ~scc_cs_s;
        offset_s = ADDR_W'({sel_bank_s & rom_mask, addr[12:0]});
        sum_s    = rom_base + offset_s;
        if (ram_cs_s) begin
            out_addr = sum_s;
        end else begin
            out_addr = {ADDR_W{1'b1}};
        end
    end

    assign out_ram_cs  = ram_cs_s;
    assign out_sram_cs = 1'b0;
    assign out_rnw     = 1'b1;
    assign scc_cs      = scc_cs_s;
    assign scc_en      = scc_en_s;

endmodule

// File: tb/tb_mapper_konami_gen.sv
// ---------------------------------------------------------------------------
// tb_mapper_konami_gen
// Table-driven bench for the Konami mapper. One instance is built for
// MODE 0 and one for MODE 1, and both share the same bus inputs. Each
// vector drives one bus cycle just after the falling edge. The bench then
// compares the combinational outputs of the selected instance, and the
// rising edge commits any write.
// ---------------------------------------------------------------------------
module tb_mapper_konami_gen;

    localparam logic [26:0] ONES = 27'h7FFFFFF;

    logic        clk;
    logic        reset;
    logic        cs;
    logic [15:0] addr;
    logic [7:0]  data;
    logic        wr;
    logic        rd;
    logic [26:0] rom_base;
    logic [7:0]  rom_mask;

    logic [26:0] a0, a1;
    logic        ram0, ram1, sram0, sram1, rnw0, rnw1, sccs0, sccs1, scce0, scce1;

    int checks;
    int errors;

    mapper_konami_gen #(.MODE(0), .BANK_BITS(8), .ADDR_W(27)) dut0 (
        .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data(data),
        .wr(wr), .rd(rd), .rom_base(rom_base), .rom_mask(rom_mask),
        .out_addr(a0), .out_ram_cs(ram0), .out_sram_cs(sram0),
        .out_rnw(rnw0), .scc_cs(sccs0), .scc_en(scce0)
    );

    mapper_konami_gen #(.MODE(1), .BANK_BITS(8), .ADDR_W(27)) dut1 (
        .clk(clk), .reset(reset), .cs(cs), .addr(addr), .data(data),
        .wr(wr), .rd(rd), .rom_base(rom_base), .rom_mask(rom_mask),
        .out_addr(a1), .out_ram_cs(ram1), .out_sram_cs(sram1),
        .out_rnw(rnw1), .scc_cs(sccs1), .scc_en(scce1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m;
        logic        wrv;
        logic        csv;
        logic [15:0] a;
        logic [7:0]  d;
        logic [26:0] base;
        logic [7:0]  mask;
        logic        e_ram;
        logic [26:0] e_addr;
        logic        e_scc_cs;
        logic        e_scc_en;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic add(input logic m, input logic w, input logic c, input logic [15:0] a,
                       input logic [7:0] d, input logic [26:0] b, input logic [7:0] mk,
                       input logic er, input logic [26:0] ea, input logic es, input logic ee);
        vec_t v;
        v.m = m; v.wrv = w; v.csv = c; v.a = a; v.d = d; v.base = b; v.mask = mk;
        v.e_ram = er; v.e_addr = ea; v.e_scc_cs = es; v.e_scc_en = ee;
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Drive one bus cycle, check it, then let the rising edge commit it.
    task automatic apply(input vec_t v, input int idx);
        string tag;
        @(negedge clk);
        cs = v.csv; wr = v.wrv; rd = ~v.wrv; addr = v.a; data = v.d;
        rom_base = v.base; rom_mask = v.mask;
        #1;
        tag = $sformatf("v%0d_m%0d_%h", idx, v.m, v.a);
        if (v.m) begin
            chk({tag, "_ram_cs"}, {31'd0, ram1}, {31'd0, v.e_ram});
            chk({tag, "_addr"}, {5'd0, a1}, {5'd0, v.e_addr});
            chk({tag, "_scc_cs"}, {31'd0, sccs1}, {31'd0, v.e_scc_cs});
            chk({tag, "_scc_en"}, {31'd0, scce1}, {31'd0, v.e_scc_en});
        end else begin
            chk({tag, "_ram_cs"}, {31'd0, ram0}, {31'd0, v.e_ram});
            chk({tag, "_addr"}, {5'd0, a0}, {5'd0, v.e_addr});
            chk({tag, "_scc_cs"}, {31'd0, sccs0}, {31'd0, v.e_scc_cs});
            chk({tag, "_scc_en"}, {31'd0, scce0}, {31'd0, v.e_scc_en});
        end
        chk({tag, "_sram_cs"}, {30'd0, sram0, sram1}, 32'd0);
        chk({tag, "_rnw"}, {30'd0, rnw0, rnw1}, 32'd3);
        @(posedge clk);
    endtask

    initial begin
        checks = 0; errors = 0;
        reset = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        addr = 16'h0000; data = 8'h00; rom_base = 27'd0; rom_mask = 8'h0F;

        // ---------------- MODE 0: base 0, mask 0F ----------------
        vecs.delete();
        //  m     wr    cs    addr      data   base         mask   ram   addr          scc_cs scc_en
        add(1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h0000000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h0002000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h8000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h0004000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'hA000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h0006000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h6000, 8'h05, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h6123, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h000A123, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h4000, 8'h07, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h4000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h0000000, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b1, 16'h9000, 8'h3F, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h8000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h001E000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h9800, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h001F800, 1'b0, 1'b0);
        add(1'b0, 1'b1, 1'b0, 16'h6000, 8'h09, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h6000, 8'h00, 27'h0000000, 8'h0F, 1'b1, 27'h000A000, 1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'hC000, 8'h00, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 16'h6000, 8'h00, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 16'h3FFF, 8'h00, 27'h0000000, 8'h0F, 1'b0, ONES,         1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // ---------------- MODE 1: base 100000, mask 07 ----------------
        vecs.delete();
        add(1'b1, 1'b0, 1'b1, 16'hA010, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0106010, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'hB000, 8'h1D, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'hA010, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h010A010, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'hB000, 8'h1B, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'hA010, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0106010, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'hB800, 8'h02, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'hA010, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0106010, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h6000, 8'h06, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'h6000, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0102000, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h7000, 8'h04, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'h6000, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0108000, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h5000, 8'h05, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'h4000, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h010A000, 1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'h4000, 8'h00, 27'h7FFF000, 8'h07, 1'b1, 27'h0009000, 1'b0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 16'h9000, 8'h3F, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 16'h9800, 8'h00, 27'h0100000, 8'h07, 1'b0, ONES,         1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b1, 16'h8000, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h010E000, 1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h9800, 8'h55, 27'h0100000, 8'h07, 1'b0, ONES,         1'b1, 1'b1);
        add(1'b1, 1'b0, 1'b0, 16'h9800, 8'h00, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b1);
        add(1'b1, 1'b1, 1'b1, 16'h9000, 8'h00, 27'h0100000, 8'h07, 1'b0, ONES,         1'b0, 1'b1);
        add(1'b1, 1'b0, 1'b1, 16'h9800, 8'h00, 27'h0100000, 8'h07, 1'b1, 27'h0101800, 1'b0, 1'b0);
        do_reset();
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 100 + i);

        // ---- Reset sampled together with a write to 6000 keeps bank1 at 1 ----
        @(negedge clk);
        reset = 1'b1; cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 16'h6000; data = 8'h09;
        rom_base = 27'd0; rom_mask = 8'h0F;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0; wr = 1'b0; rd = 1'b1; addr = 16'h6000;
        #1;
        chk("rst_wr_m0_addr", {5'd0, a0}, 32'h0002000);
        chk("rst_wr_m1_addr", {5'd0, a1}, 32'h0002000);
        chk("rst_wr_m0_ram_cs", {31'd0, ram0}, 32'd1);

        // ---- Reset while the SCC is enabled clears it on the next cycle ----
        @(negedge clk);
        cs = 1'b1; wr = 1'b1; rd = 1'b0; addr = 16'h9000; data = 8'h3F;
        @(negedge clk);
        wr = 1'b0; rd = 1'b1; addr = 16'h9800;
        #1;
        chk("scc_on_before_rst", {31'd0, sccs1}, 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("scc_en_after_rst", {31'd0, scce1}, 32'd0);
        chk("scc_rst_addr", {5'd0, a1}, 32'h0005800);
        cs = 1'b0; rd = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
